// File: rtl/altera_safe_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : altera_safe_rr_arbiter                                        |
// | Purpose  : Round-robin arbiter with a registered one-hot grant, a dead   |
// |            cycle between owners and a self-recovering "safe" FSM.        |
// |            Define ALTERA_SAFE_ARB_WATCHDOG_EN to add the hold watchdog.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module altera_safe_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout,
  output logic                    fsm_err
);

  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] c_lsb = NREQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  if ((NREQ < 2) || (NREQ > 16) || (MAX_HOLD < 2)) begin : g_param_check
    $error("altera_safe_rr_arbiter: NREQ must be 2..16 and MAX_HOLD >= 2");
  end

  // Plain 2-bit vector rather than state_t so the unused code 3 stays representable.
  (* syn_encoding = "safe" *) logic [1:0] r_state;
  logic [1:0]      w_state_nxt;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0] w_grant_nxt;
  logic [IW-1:0]   w_id_nxt;
  logic            w_busy_nxt;
  logic            w_err_nxt;
  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_elig;
  logic            w_expire;
  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_idx;

  assign w_elig = req & ~w_mask;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = grant;
    w_id_nxt    = grant_id;
    w_busy_nxt  = busy;
    w_err_nxt   = 1'b0;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_found) begin
          w_state_nxt = ST_OWN;
          w_grant_nxt = c_lsb << w_win;
          w_id_nxt    = w_win;
          w_busy_nxt  = 1'b1;
          w_ptr_nxt   = (w_win == IW'(NREQ-1)) ? '0 : w_win + 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      ST_OWN: begin
        // A dropped request wins over watchdog expiry: it is a plain release.
        if (!req[grant_id] || w_expire) begin
          w_state_nxt = ST_GAP;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_id_nxt    = '0;
        w_busy_nxt  = 1'b0;
        w_err_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      fsm_err  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      grant    <= w_grant_nxt;
      grant_id <= w_id_nxt;
      busy     <= w_busy_nxt;
      fsm_err  <= w_err_nxt;
    end
  end

`ifdef ALTERA_SAFE_ARB_WATCHDOG_EN
  localparam int HW = $clog2(MAX_HOLD);

  logic [HW-1:0]   r_hold;
  logic [NREQ-1:0] r_mask;
  logic            r_timeout;
  logic            w_reclaim;
  logic            w_legal;

  assign w_expire  = (r_hold == HW'(MAX_HOLD-1));
  assign w_mask    = r_mask;
  assign w_reclaim = (r_state == ST_OWN) && req[grant_id] && w_expire;
  assign w_legal   = (r_state == ST_IDLE) || (r_state == ST_OWN) || (r_state == ST_GAP);
  assign timeout   = r_timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold    <= '0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
    end else if (!w_legal) begin
      r_hold    <= '0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_reclaim;
      // Mask the reclaimed owner until it drops its request at least once.
      r_mask    <= (r_mask & req) | (w_reclaim ? (c_lsb << grant_id) : '0);
      if (r_state != ST_OWN) begin
        r_hold <= '0;
      end else if (!w_expire) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end
`else
  assign w_expire = 1'b0;
  assign w_mask   = '0;
  assign timeout  = 1'b0;
`endif

endmodule
`default_nettype wire
